// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the load / writeback-select encodings.
// Latency: none (types and constants only).
// Backpressure: none.
package cpu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  // Load width/sign encoding carried down the pipe from decode; unknown codes act as LW
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  // Writeback source select; 2'b11 is unassigned and falls back to the ALU result
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends the addressed byte/half/word from a little-endian memory word.
// Latency: purely combinational.
// Backpressure: none; also reports whether the access is misaligned for its width.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] out_data,
  output logic            out_misalign
);

  logic [4:0]  w_bsel;
  logic [4:0]  w_hsel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsel = {offset, 3'b000};
  assign w_hsel = {offset[1], 4'b0000};
  assign w_byte = in_mem_rdata[w_bsel +: 8];
  assign w_half = in_mem_rdata[w_hsel +: 16];

  // Pick the lane for the access width and extend it; flag halves on odd bytes and unaligned words
  always_comb begin
    out_data     = in_mem_rdata;
    out_misalign = 1'b0;
    case (load_type)
      LT_LB:  out_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LT_LBU: out_data = {{(XLEN-8){1'b0}}, w_byte};
      LT_LH: begin
        out_data     = {{(XLEN-16){w_half[15]}}, w_half};
        out_misalign = offset[0];
      end
      LT_LHU: begin
        out_data     = {{(XLEN-16){1'b0}}, w_half};
        out_misalign = offset[0];
      end
      default: begin
        out_data     = in_mem_rdata;
        out_misalign = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, selects the writeback value, drives the regfile port and forwarding tap.
// Latency: one cycle input to output; every output comes straight from a flop.
// Backpressure: stall holds all state (regfile rewrite is idempotent), flush kills the captured instruction and overrides stall.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [1:0]         in_wb_sel,
  input  logic [2:0]         in_load_type,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_pc_plus4,
  input  logic [XLEN-1:0]    in_mem_rdata,
  output logic               L_S,
  output logic [RADDR_W-1:0] Wt_addr,
  output logic [XLEN-1:0]    wt_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic               load_misalign,
  output logic [31:0]        instret
);

  logic [XLEN-1:0]    w_load_data;
  logic               w_align_err;
  logic               w_misalign;
  logic               w_wen;
  logic [XLEN-1:0]    w_wdata;

  logic               r_valid;
  logic               r_wen;
  logic [RADDR_W-1:0] r_rd;
  logic [XLEN-1:0]    r_wdata;
  logic               r_misalign;
  logic [31:0]        r_instret;

  load_align #(.XLEN(XLEN)) u_load_align (
    .in_mem_rdata (in_mem_rdata),
    .offset       (in_alu_result[1:0]),
    .load_type    (in_load_type),
    .out_data     (w_load_data),
    .out_misalign (w_align_err)
  );

  // Alignment only matters for real instructions that actually take the load result
  assign w_misalign = in_valid & (in_wb_sel == WB_MEM) & w_align_err;
  assign w_wen      = in_valid & in_reg_write & (in_rd != '0) & ~w_misalign;

  // Writeback source mux; the reserved select code falls through to the ALU result
  always_comb begin
    w_wdata = in_alu_result;
    case (in_wb_sel)
      WB_MEM:  w_wdata = w_load_data;
      WB_LINK: w_wdata = in_pc_plus4;
      default: w_wdata = in_alu_result;
    endcase
  end

  // Pipeline register: flush beats stall beats capture; data/address are left stale on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_wen      <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
      r_instret  <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_wen      <= 1'b0;
      r_misalign <= 1'b0;
    end else if (!stall) begin
      r_valid    <= in_valid;
      r_wen      <= w_wen;
      r_rd       <= in_rd;
      r_wdata    <= w_wdata;
      r_misalign <= w_misalign;
      if (in_valid && !w_misalign) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // Write enable already implies a valid instruction; the AND keeps the tap tied to a live stage
  assign L_S           = r_wen;
  assign Wt_addr       = r_rd;
  assign wt_data       = r_wdata;
  assign fwd_valid     = r_valid & r_wen;
  assign fwd_rd        = r_rd;
  assign fwd_data      = r_wdata;
  assign load_misalign = r_misalign;
  assign instret       = r_instret;

endmodule
